div_unit: RTL and testbench

Multi-cycle 32-bit integer divider in the EX stage, implementing MIPS DIV/DIVU. While a division is in progress it drives `stall_request`, which the pipeline stall controller turns into a freeze of PC through EX. When the divider holds a valid result it releases the stall so the instruction can leave EX with {HI, LO} = {remainder, quotient}.

---
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for MIPS DIV/DIVU, result = {remainder, quotient}.
// Latency: WIDTH+1 cycles from start to ready (2 cycles for a zero divisor).
// Backpressure: stall_request holds the pipeline until ready; DONE holds while start stays high.
// Optional macro DIV_SIGNED_EN enables signed DIV; without it every division is unsigned.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               cancel,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_request
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BYZERO, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;    // partial remainder (always < divisor, so WIDTH bits suffice)
  logic [WIDTH-1:0] quot;   // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dsr;    // latched divisor magnitude

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_next, r_next, q_fin, r_fin;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  // Operand magnitudes for signed division; the most negative value maps to itself as unsigned
  assign a_neg = signed_div & dividend[WIDTH-1];
  assign b_neg = signed_div & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;
  assign q_fin = neg_q ? -q_next : q_next;
  assign r_fin = neg_r ? -r_next : r_next;
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = q_next;
  assign r_fin = r_next;
`endif

  // One restoring step: shift in the next dividend bit, keep the trial difference if non-negative
  assign shifted = {rem, quot[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};
  assign q_next  = {quot[WIDTH-2:0], ~trial[WIDTH]};
  assign r_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

  // Stall whenever EX holds a divide whose result is not yet available
  assign stall_request = start & ~ready & ~cancel;

  // Control FSM and datapath registers; cancel wins over every state transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      rem    <= '0;
      quot   <= '0;
      dsr    <= '0;
      result <= '0;
      ready  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else if (cancel) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              result <= '0;
              state  <= BYZERO;
            end else begin
              rem   <= '0;
              quot  <= a_mag;
              dsr   <= b_mag;
              count <= '0;
`ifdef DIV_SIGNED_EN
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
`endif
              state <= BUSY;
            end
          end
        end
        BYZERO: begin
          state <= DONE;
          ready <= 1'b1;
        end
        BUSY: begin
          rem   <= r_next;
          quot  <= q_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            result <= {r_fin, q_fin};
            ready  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and randomized checks of div_unit against an arithmetic model.
// Covers latency/stall length, divide-by-zero, DONE hold, cancel and asynchronous reset.
// Build with or without DIV_SIGNED_EN; expectations follow the same macro.
module tb_div_unit;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, signed_div, cancel;
  logic [31:0] dividend, divisor;
  logic [63:0] result;
  logic        ready, stall_request;

  int checks = 0;
  int failures = 0;
  logic [63:0] last_result;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[8];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_div(signed_div),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .result(result), .ready(ready), .stall_request(stall_request)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder follows the dividend
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [63:0] exp, input string nm, input int hold);
    int cyc, stalls, lat;
    @(negedge clk);
    dividend = a; divisor = b; signed_div = sg; start = 1'b1;
    #1;
    cyc = 0; stalls = 0;
    lat = (b == 32'd0) ? 2 : 33;
    while (!ready && cyc < 100) begin
      if (stall_request) stalls++;
      @(negedge clk); #1;
      cyc++;
      dividend = $urandom; divisor = $urandom;
    end
    check({nm, " stall_cycles"}, 64'(stalls), 64'(lat));
    check({nm, " ready_latency"}, 64'(cyc), 64'(lat));
    check({nm, " result"}, result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check({nm, " hold_ready_nostall"}, {62'd0, ready, stall_request}, 64'd2);
      check({nm, " hold_result"}, result, exp);
    end
    start = 1'b0;
    @(negedge clk); #1;
    check({nm, " ready_drop"}, 64'(ready), 64'd0);
    last_result = exp;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    tbl[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2};
    tbl[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1,
               SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
               SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001};
    tbl[2] = '{32'd5, 32'd0, 1'b0, 32'd0, 32'd0};
    tbl[3] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0};
    tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               SIGNED_EN ? 32'h8000_0000 : 32'd0,
               SIGNED_EN ? 32'd0 : 32'h8000_0000};
    tbl[5] = '{32'd7, 32'hFFFF_FFFE, 1'b1,
               SIGNED_EN ? 32'hFFFF_FFFD : 32'd0,
               SIGNED_EN ? 32'd1 : 32'd7};
    tbl[6] = '{32'd12345678, 32'd1000, 1'b0, 32'd12345, 32'd678};
    tbl[7] = '{32'd3, 32'd10, 1'b0, 32'd0, 32'd3};

    reset = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    check("reset_state", {result, ready, stall_request}, 66'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i])
      run_div(tbl[i].a, tbl[i].b, tbl[i].sg, {tbl[i].r, tbl[i].q},
              $sformatf("vec%0d", i), (i == 0) ? 5 : 1);

    // Cancel after 10 iterations: back to IDLE, result untouched
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (11) begin @(negedge clk); #1; end
    cancel = 1'b1; #1;
    check("cancel_stall_low", 64'(stall_request), 64'd0);
    @(negedge clk);
    cancel = 1'b0; start = 1'b0; #1;
    check("cancel_idle", {62'd0, ready, stall_request}, 64'd0);
    check("cancel_result_kept", result, last_result);
    run_div(32'd1000, 32'd33, 1'b0, model(32'd1000, 32'd33, 1'b0), "after_cancel", 0);

    // Asynchronous reset in the middle of iteration 20
    @(negedge clk);
    dividend = 32'h1234_5678; divisor = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (21) begin @(negedge clk); #1; end
    #1 reset = 1'b1;
    #1;
    check("async_reset", {result, ready}, 65'd0);
    start = 1'b0;
    #2 reset = 1'b0;
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, "after_reset", 0);

    // Randomized operands against the arithmetic model
    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (k % 8 == 3) rb = 32'd0;
      rs = 1'($urandom_range(0, 1));
      run_div(ra, rb, rs, model(ra, rb, rs), $sformatf("rand%0d", k), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
